// File: rtl/gold_correlator.sv
// Receive-side despreader for the 63-chip gold code.
// Samples a 1-bit chip stream, scores every 63-chip window against GOLD,
// acquires on a true or inverted peak and then emits one BPSK decision per
// 63-chip epoch until MISS_MAX consecutive epochs go unmatched.
module gold_correlator #(
    parameter int unsigned CLK_DIV      = 8,
    parameter int unsigned SAMPLE_PHASE = 4,
    parameter logic [62:0] GOLD         = 63'b000001000011000101001111010001110010010110111011001101010111111,
    parameter int unsigned THRESH       = 56,
    parameter int unsigned MISS_MAX     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       rx_bit,
    output logic [5:0] score,
    output logic       score_valid,
    output logic       peak,
    output logic       locked,
    output logic       sym_valid,
    output logic       sym_hit,
    output logic       sym_bit
);

    localparam int unsigned DW          = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SCORE_PHASE = (SAMPLE_PHASE + 1) % CLK_DIV;

    typedef enum logic {
        SEARCH,
        LOCKED
    } state_t;

    state_t        state_q;
    logic [DW-1:0] div_q, div_d;
    logic          sample_s, score_s;
    logic [62:0]   win_q;
    logic [5:0]    fill_q;
    logic [5:0]    epoch_q;
    logic [7:0]    miss_q;
    logic [5:0]    score_d, score_q;
    logic          hit_t, hit_i;
    logic          score_valid_q, peak_q, locked_q;
    logic          sym_valid_q, sym_hit_q, sym_bit_q;

    // Chip divider next state and the sample/score strobes derived from it.
    // Scoring runs on the divider count after the sample so that the window
    // it sees is the one just shifted; both strobes stop while en is low.
    always_comb begin
        div_d = div_q;
        if (en) begin
            div_d = (div_q == DW'(CLK_DIV - 1)) ? '0 : div_q + 1'b1;
        end
        sample_s = en && (div_q == DW'(SAMPLE_PHASE));
        score_s  = en && (div_q == DW'(SCORE_PHASE));
    end

    // Agreement count of the current window and the peak decisions on it.
    always_comb begin
        logic [62:0] agree;
        agree   = ~(win_q ^ GOLD);
        score_d = '0;
        for (int unsigned i = 0; i < 63; i++) begin
            score_d = score_d + 6'(agree[i]);
        end
        hit_t = (score_d >= 6'(THRESH));
        hit_i = (score_d <= 6'(63 - THRESH));
    end

    // Divider, chip window shift and saturating fill counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= '0;
            win_q  <= '0;
            fill_q <= '0;
        end else begin
            div_q <= div_d;
            if (sample_s) begin
                win_q <= {rx_bit, win_q[62:1]};
                if (fill_q != 6'd63) begin
                    fill_q <= fill_q + 6'd1;
                end
            end
        end
    end

    // Registered score and its one-cycle valid strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            score_q       <= '0;
            score_valid_q <= 1'b0;
        end else begin
            score_valid_q <= score_s;
            if (score_s) begin
                score_q <= score_d;
            end
        end
    end

    // Acquisition / tracking FSM with registered pulse outputs.
    // locked follows the state one cycle late so it drops the cycle after the
    // final miss, but is forced high on the acquiring edge to coincide with peak.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SEARCH;
            epoch_q     <= '0;
            miss_q      <= '0;
            peak_q      <= 1'b0;
            locked_q    <= 1'b0;
            sym_valid_q <= 1'b0;
            sym_hit_q   <= 1'b0;
            sym_bit_q   <= 1'b0;
        end else begin
            peak_q      <= 1'b0;
            sym_valid_q <= 1'b0;
            sym_hit_q   <= 1'b0;
            sym_bit_q   <= 1'b0;
            locked_q    <= (state_q == LOCKED);
            if (score_s) begin
                case (state_q)
                    SEARCH: begin
                        if ((fill_q == 6'd63) && (hit_t || hit_i)) begin
                            peak_q   <= 1'b1;
                            locked_q <= 1'b1;
                            state_q  <= LOCKED;
                            epoch_q  <= '0;
                            miss_q   <= '0;
                        end
                    end
                    LOCKED: begin
                        if (epoch_q == 6'd62) begin
                            epoch_q     <= '0;
                            sym_valid_q <= 1'b1;
                            if (hit_t || hit_i) begin
                                peak_q    <= 1'b1;
                                sym_hit_q <= 1'b1;
                                sym_bit_q <= hit_i;
                                miss_q    <= '0;
                            end else begin
                                miss_q <= miss_q + 8'd1;
                                if ((miss_q + 8'd1) >= 8'(MISS_MAX)) begin
                                    state_q <= SEARCH;
                                end
                            end
                        end else begin
                            epoch_q <= epoch_q + 6'd1;
                        end
                    end
                    default: state_q <= SEARCH;
                endcase
            end
        end
    end

    assign score       = score_q;
    assign score_valid = score_valid_q;
    assign peak        = peak_q;
    assign locked      = locked_q;
    assign sym_valid   = sym_valid_q;
    assign sym_hit     = sym_hit_q;
    assign sym_bit     = sym_bit_q;

endmodule
